writeback_queue: RTL and testbench
==================================

Name: writeback_queue

Overview:
- Producer side of the register-file write port.
- Accepts completed results (destination index + data) from the memory/retire stage on a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains one entry per cycle onto the wr_en / stage5_rd / stage5_result write port.
- Exports a pending-destination mask so decode can detect RAW hazards against writes that have not yet landed.

Parameters:
- BUS_DATA_WIDTH, 64: width of result data.
- DEPTH, 4: FIFO entries. Power of two, >= 2.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  synchronous, active-low; 0 at a posedge clears all state.
- in_valid  input  1  producer has a result.
- in_ready  output  1  queue can accept this cycle.
- in_rd  input  5  destination register index.
- in_result  input  BUS_DATA_WIDTH  result data.
- stall_wb  input  1  1 = hold the write port idle this cycle.
- wr_en  output  1  register-file write strobe.
- stage5_rd  output  5  write destination index.
- stage5_result  output  BUS_DATA_WIDTH  write data.
- busy_mask  output  32  bit r = 1 if any queued entry targets register r.
- count  output  $clog2(DEPTH)+1  number of queued entries.

Behaviour:
- Storage: DEPTH entries of {rd, result}. Read/write pointers are modulo DEPTH and wrap with no bubble. count is a separate register.
- in_ready = (count != DEPTH). It is combinational from registered count only, and carries no same-cycle dequeue credit.
- Accept condition: in_valid && in_ready at a posedge.
  - If in_rd != 0: the entry is written at the write pointer, the pointer increments, and count increments.
  - If in_rd == 0: the handshake completes but the entry is discarded. Pointers and count are unchanged. x0 is never written.
- Drain: wr_en = (count != 0) && !stall_wb, combinational.
  - stage5_rd and stage5_result present the head entry whenever count != 0; both are 0 when empty.
  - A posedge with wr_en = 1 pops the head (read pointer increments, count decrements).
- Latency: an entry accepted at edge N appears on wr_en in the cycle after edge N, provided the queue was empty and stall_wb = 0. Otherwise it waits behind older entries. Writes occur strictly in accept order.
- Simultaneous push and pop: count is unchanged and both pointers advance. Allowed at any count < DEPTH.
- Full: in_ready = 0 even if a pop occurs the same cycle. The producer must hold in_valid/in_rd/in_result stable until accepted.
- stall_wb = 1: no pop, entries are retained, and enqueue continues until full.
- busy_mask: combinational OR of one-hot(rd) over all valid entries, including the head being written this cycle. Bit 0 is always 0.
- Reset (reset = 0 at posedge): count = 0, pointers = 0, and busy_mask, wr_en, stage5_rd and stage5_result read 0. in_ready = 1 after release. Asserting reset mid-operation discards all queued entries, and no write is issued in the reset cycle.
- No X propagation: unwritten storage is never presented on outputs.

Optional Feature:
- WB_BYPASS_EN: when defined, adds these ports:
  - inputs stage1_rs1[4:0], stage1_rs2[4:0]
  - outputs byp_rs1_hit, byp_rs2_hit (1 bit each)
  - outputs byp_rs1_data, byp_rs2_data (BUS_DATA_WIDTH each)
- Lookup is combinational over valid entries and selects the youngest matching entry. A source index of 0 always yields hit = 0, data = 0.
- Without the macro, these ports and the lookup logic do not exist. Hazards are resolved by stalling on busy_mask.

Test Plan:
- Single push: reset, then push rd = 5, result = 0xDEAD with stall_wb = 0 → next cycle wr_en = 1, stage5_rd = 5, stage5_result = 0xDEAD, busy_mask = 0x20; the cycle after, count = 0 and wr_en = 0.
- x0 drop: push rd = 0, result = 0x1234 → in_ready = 1, count stays 0, wr_en never asserts, busy_mask = 0.
- Fill and stall: stall_wb = 1, push rd = 1,2,3,4 → count = 4, in_ready = 0, busy_mask = 0x1E, and a 5th push is held. Release stall → writes emerge in order 1,2,3,4 on consecutive cycles, and the 5th is accepted the cycle after count drops to 3.
- Wrap with concurrent push/pop: stream 10 back-to-back pushes rd = 1..10 with stall_wb = 0 → count never exceeds 1 and all 10 writes appear in order, one cycle after each accept.
- Reset mid-operation: 3 entries queued, assert reset for 1 cycle → count = 0, wr_en = 0, busy_mask = 0, and no queued entry is ever written.
- WB_BYPASS_EN: with stall_wb = 1, queue rd = 7 / 0xA then rd = 7 / 0xB, and set stage1_rs1 = 7 → byp_rs1_hit = 1, byp_rs1_data = 0xB; stage1_rs2 = 0 → hit = 0, data = 0.

Source files
------------

// File: rtl/writeback_queue.sv
// Register-file write-port queue: in-order FIFO of {rd, result} drained one entry per cycle,
// with a pending-destination mask for decode. Define WB_BYPASS_EN for the source-operand bypass lookup.
module writeback_queue #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int DEPTH          = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4:0]                in_rd,
    input  logic [BUS_DATA_WIDTH-1:0] in_result,
    input  logic                      stall_wb,
    output logic                      wr_en,
    output logic [4:0]                stage5_rd,
    output logic [BUS_DATA_WIDTH-1:0] stage5_result,
    output logic [31:0]               busy_mask,
    output logic [$clog2(DEPTH):0]    count
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]                stage1_rs1,
    input  logic [4:0]                stage1_rs2,
    output logic                      byp_rs1_hit,
    output logic                      byp_rs2_hit,
    output logic [BUS_DATA_WIDTH-1:0] byp_rs1_data,
    output logic [BUS_DATA_WIDTH-1:0] byp_rs2_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [4:0]                ent_rd_q   [DEPTH];
    logic [4:0]                ent_rd_d   [DEPTH];
    logic [BUS_DATA_WIDTH-1:0] ent_data_q [DEPTH];
    logic [BUS_DATA_WIDTH-1:0] ent_data_d [DEPTH];
    logic [DEPTH-1:0]          ent_vld;
    logic                      head_vld;
    logic                      push;
    logic                      pop;

    // Outputs are masked while reset is low so nothing is written in the reset cycle.
    always_comb begin
        in_ready      = (count_q != FULL_CNT);
        head_vld      = (count_q != '0) && reset;
        push          = in_valid && in_ready && (in_rd != 5'd0) && reset;
        pop           = head_vld && !stall_wb;
        wr_en         = pop;
        stage5_rd     = head_vld ? ent_rd_q[rd_ptr_q]   : 5'd0;
        stage5_result = head_vld ? ent_data_q[rd_ptr_q] : '0;
        count         = count_q;
    end

    always_comb begin
        ent_vld = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < count_q) begin
                ent_vld[rd_ptr_q + PTR_W'(k)] = 1'b1;
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && reset) begin
                busy_mask[ent_rd_q[i]] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ent_rd_d   = ent_rd_q;
        ent_data_d = ent_data_q;
        if (push) begin
            ent_rd_d[wr_ptr_q]   = in_rd;
            ent_data_d[wr_ptr_q] = in_result;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd_q[i]   <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ent_rd_q   <= ent_rd_d;
            ent_data_q <= ent_data_d;
        end
    end

`ifdef WB_BYPASS_EN
    logic [PTR_W-1:0] byp_idx;

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        byp_idx      = '0;
        byp_rs1_hit  = 1'b0;
        byp_rs2_hit  = 1'b0;
        byp_rs1_data = '0;
        byp_rs2_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            byp_idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && reset) begin
                if ((stage1_rs1 != 5'd0) && (ent_rd_q[byp_idx] == stage1_rs1)) begin
                    byp_rs1_hit  = 1'b1;
                    byp_rs1_data = ent_data_q[byp_idx];
                end
                if ((stage1_rs2 != 5'd0) && (ent_rd_q[byp_idx] == stage1_rs2)) begin
                    byp_rs2_hit  = 1'b1;
                    byp_rs2_data = ent_data_q[byp_idx];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed vector table, then a queue scoreboard for streaming and random traffic.
module tb_writeback_queue;

    localparam int W     = 64;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_rd;
    logic [W-1:0]  in_result;
    logic          stall_wb;
    logic          wr_en;
    logic [4:0]    stage5_rd;
    logic [W-1:0]  stage5_result;
    logic [31:0]   busy_mask;
    logic [2:0]    count;
`ifdef WB_BYPASS_EN
    logic [4:0]    stage1_rs1;
    logic [4:0]    stage1_rs2;
    logic          byp_rs1_hit;
    logic          byp_rs2_hit;
    logic [W-1:0]  byp_rs1_data;
    logic [W-1:0]  byp_rs2_data;
`endif

    always #5 clk = ~clk;

    writeback_queue #(.BUS_DATA_WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd        (in_rd),
        .in_result    (in_result),
        .stall_wb     (stall_wb),
        .wr_en        (wr_en),
        .stage5_rd    (stage5_rd),
        .stage5_result(stage5_result),
        .busy_mask    (busy_mask),
        .count        (count)
`ifdef WB_BYPASS_EN
        ,
        .stage1_rs1   (stage1_rs1),
        .stage1_rs2   (stage1_rs2),
        .byp_rs1_hit  (byp_rs1_hit),
        .byp_rs2_hit  (byp_rs2_hit),
        .byp_rs1_data (byp_rs1_data),
        .byp_rs2_data (byp_rs2_data)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        vld;
        logic [4:0]  rd;
        logic [63:0] res;
        logic        stall;
        logic        rdy;
        logic        wr;
        logic [4:0]  wrd;
        logic [63:0] wres;
        logic [2:0]  cnt;
        logic [31:0] busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_n, input logic vld, input logic [4:0] rd, input logic [63:0] res,
                       input logic stall, input logic rdy, input logic wr, input logic [4:0] wrd,
                       input logic [63:0] wres, input logic [2:0] cnt, input logic [31:0] busy);
        vec_t v;
        v.rst_n = rst_n; v.vld = vld; v.rd = rd; v.res = res; v.stall = stall;
        v.rdy = rdy; v.wr = wr; v.wrd = wrd; v.wres = wres; v.cnt = cnt; v.busy = busy;
        vecs.push_back(v);
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    ent_t exp_q[$];

    // One clock of traffic checked against the reference queue, which is then advanced.
    task automatic sb_cycle(input logic vld, input logic [4:0] rd, input logic [63:0] res,
                            input logic stall, output logic acc);
        logic        exp_ready;
        logic        exp_wr;
        logic [31:0] exp_busy;
        ent_t        e;
        @(posedge clk);
        #1;
        reset     = 1'b1;
        in_valid  = vld;
        in_rd     = rd;
        in_result = res;
        stall_wb  = stall;
        #3;
        exp_ready = (exp_q.size() != DEPTH);
        exp_wr    = (exp_q.size() != 0) && !stall;
        exp_busy  = '0;
        foreach (exp_q[i]) exp_busy[exp_q[i].rd] = 1'b1;
        check("sb_in_ready", in_ready, exp_ready);
        check("sb_wr_en", wr_en, exp_wr);
        check("sb_count", count, exp_q.size());
        check("sb_busy_mask", busy_mask, exp_busy);
        if (exp_q.size() != 0) begin
            check("sb_stage5_rd", stage5_rd, exp_q[0].rd);
            check("sb_stage5_result", stage5_result, exp_q[0].data);
        end else begin
            check("sb_stage5_rd_idle", stage5_rd, 0);
            check("sb_stage5_result_idle", stage5_result, 0);
        end
        acc = vld && exp_ready;
        if (exp_wr) void'(exp_q.pop_front());
        if (acc && rd != 5'd0) begin
            e.rd   = rd;
            e.data = res;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic        have;
        logic        stl;
        logic [4:0]  prd;
        logic [63:0] pres;

        reset = 1'b0; in_valid = 1'b0; in_rd = '0; in_result = '0; stall_wb = 1'b0;
`ifdef WB_BYPASS_EN
        stage1_rs1 = '0; stage1_rs2 = '0;
`endif
        repeat (2) @(posedge clk);

        //   rst vld rd  res      stl rdy wr wrd  wres     cnt busy
        add(0, 0, 0,  64'h0,    0,  1,  0, 0,  64'h0,    0, 32'h0);
        add(1, 1, 5,  64'hDEAD, 0,  1,  0, 0,  64'h0,    0, 32'h0);
        add(1, 0, 0,  64'h0,    0,  1,  1, 5,  64'hDEAD, 1, 32'h20);
        add(1, 0, 0,  64'h0,    0,  1,  0, 0,  64'h0,    0, 32'h0);
        add(1, 1, 0,  64'h1234, 0,  1,  0, 0,  64'h0,    0, 32'h0);
        add(1, 0, 0,  64'h0,    0,  1,  0, 0,  64'h0,    0, 32'h0);
        add(1, 1, 1,  64'h11,   1,  1,  0, 0,  64'h0,    0, 32'h0);
        add(1, 1, 2,  64'h22,   1,  1,  0, 1,  64'h11,   1, 32'h02);
        add(1, 1, 3,  64'h33,   1,  1,  0, 1,  64'h11,   2, 32'h06);
        add(1, 1, 4,  64'h44,   1,  1,  0, 1,  64'h11,   3, 32'h0E);
        add(1, 1, 6,  64'h66,   1,  0,  0, 1,  64'h11,   4, 32'h1E);
        add(1, 1, 6,  64'h66,   1,  0,  0, 1,  64'h11,   4, 32'h1E);
        add(1, 1, 6,  64'h66,   0,  0,  1, 1,  64'h11,   4, 32'h1E);
        add(1, 1, 6,  64'h66,   0,  1,  1, 2,  64'h22,   3, 32'h1C);
        add(1, 0, 0,  64'h0,    0,  1,  1, 3,  64'h33,   3, 32'h58);
        add(1, 0, 0,  64'h0,    0,  1,  1, 4,  64'h44,   2, 32'h50);
        add(1, 0, 0,  64'h0,    0,  1,  1, 6,  64'h66,   1, 32'h40);
        add(1, 0, 0,  64'h0,    0,  1,  0, 0,  64'h0,    0, 32'h0);
        add(1, 1, 9,  64'h99,   1,  1,  0, 0,  64'h0,    0, 32'h0);
        add(1, 1, 10, 64'hAA,   1,  1,  0, 9,  64'h99,   1, 32'h200);
        add(1, 1, 11, 64'hBB,   1,  1,  0, 9,  64'h99,   2, 32'h600);
        add(1, 0, 0,  64'h0,    1,  1,  0, 9,  64'h99,   3, 32'hE00);
        add(0, 0, 0,  64'h0,    0,  1,  0, 0,  64'h0,    3, 32'h0);
        add(1, 0, 0,  64'h0,    0,  1,  0, 0,  64'h0,    0, 32'h0);
        add(1, 1, 12, 64'hCC,   0,  1,  0, 0,  64'h0,    0, 32'h0);
        add(1, 0, 0,  64'h0,    0,  1,  1, 12, 64'hCC,   1, 32'h1000);
        add(1, 0, 0,  64'h0,    0,  1,  0, 0,  64'h0,    0, 32'h0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            reset = vecs[i].rst_n; in_valid = vecs[i].vld; in_rd = vecs[i].rd;
            in_result = vecs[i].res; stall_wb = vecs[i].stall;
            #3;
            check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].rdy);
            check($sformatf("vec%0d_wr_en", i), wr_en, vecs[i].wr);
            check($sformatf("vec%0d_stage5_rd", i), stage5_rd, vecs[i].wrd);
            check($sformatf("vec%0d_stage5_result", i), stage5_result, vecs[i].wres);
            check($sformatf("vec%0d_count", i), count, vecs[i].cnt);
            check($sformatf("vec%0d_busy_mask", i), busy_mask, vecs[i].busy);
        end

        exp_q.delete();
        for (int i = 1; i <= 10; i++) begin
            sb_cycle(1'b1, 5'(i), 64'h1000 + 64'(i), 1'b0, acc);
            check("stream_count_le1", (count <= 3'd1), 1);
        end
        for (int i = 0; i < 2; i++) sb_cycle(1'b0, 5'd0, 64'h0, 1'b0, acc);

        have = 1'b0; prd = '0; pres = '0;
        for (int c = 0; c < 300; c++) begin
            if (!have && ($urandom_range(0, 2) != 0)) begin
                have = 1'b1;
                prd  = 5'($urandom_range(0, 31));
                pres = {$urandom, $urandom};
            end
            stl = (c < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            sb_cycle(have, have ? prd : 5'd0, have ? pres : 64'h0, stl, acc);
            if (acc) have = 1'b0;
        end
        for (int c = 0; c < DEPTH + 2; c++) sb_cycle(1'b0, 5'd0, 64'h0, 1'b0, acc);

`ifdef WB_BYPASS_EN
        sb_cycle(1'b1, 5'd7, 64'hA, 1'b1, acc);
        sb_cycle(1'b1, 5'd7, 64'hB, 1'b1, acc);
        stage1_rs1 = 5'd7;
        stage1_rs2 = 5'd0;
        sb_cycle(1'b0, 5'd0, 64'h0, 1'b1, acc);
        check("byp_rs1_hit", byp_rs1_hit, 1);
        check("byp_rs1_data", byp_rs1_data, 64'hB);
        check("byp_rs2_hit_x0", byp_rs2_hit, 0);
        check("byp_rs2_data_x0", byp_rs2_data, 0);
        stage1_rs2 = 5'd9;
        #1;
        check("byp_rs2_miss", byp_rs2_hit, 0);
        for (int c = 0; c < DEPTH + 2; c++) sb_cycle(1'b0, 5'd0, 64'h0, 1'b0, acc);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
